// File: rtl/ascii_loader.sv
// Replays an HPS "Load Ascii" download into the ACIA receive path as paced serial input.
// The UART owns the RX path until a download starts; the loader gives it back once the FIFO has drained.
module ascii_loader #(
    parameter int FIFO_AW  = 4,
    parameter int CHAR_GAP = 50000,
    parameter int CR_GAP   = 2500000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_data,
    output logic       ioctl_wait,
    input  logic [7:0] uart_data,
    input  logic       uart_ready,
    output logic       uart_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ack,
    output logic       busy
);

    localparam logic [2:0] PASS    = 3'd0;
    localparam logic [2:0] HANDOFF = 3'd1;
    localparam logic [2:0] FETCH   = 3'd2;
    localparam logic [2:0] PRESENT = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;

    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int GAP_MAX = (CR_GAP > CHAR_GAP) ? CR_GAP : CHAR_GAP;
    localparam int GAP_W   = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);

    localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   WAIT_LVL = (FIFO_AW + 1)'(DEPTH - 2);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [GAP_W-1:0]   CHAR_GAP_C = GAP_W'(CHAR_GAP);
    localparam logic [GAP_W-1:0]   CR_GAP_C   = GAP_W'(CR_GAP);
    localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    logic [2:0]         state;
    logic               dl_q;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [7:0]         out_byte;
    logic [GAP_W-1:0]   gap_cnt;
    logic               cr_follow;

    logic               wr_en;
    logic               pop;
    logic [7:0]         pop_byte;
    logic [7:0]         kept_byte;
    logic               keep;
    logic               pass_path;

    assign wr_en    = ioctl_wr && ioctl_download && (count != DEPTH_C);
    assign pop      = (state == FETCH) && (count != '0);
    assign pop_byte = mem[rd_ptr] & 8'h7F;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        keep      = 1'b0;
        kept_byte = pop_byte;
        if (pop_byte == CH_LF) begin
            kept_byte = CH_CR;
            keep      = !cr_follow;
        end else if (pop_byte != 8'h00) begin
            keep = 1'b1;
        end
    end

    // NOTE: the storage array has no reset; flushing the pointers and count is enough to empty the FIFO.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= ioctl_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state      <= PASS;
            dl_q       <= 1'b0;
            out_byte   <= 8'h00;
            gap_cnt    <= '0;
            cr_follow  <= 1'b0;
            ioctl_wait <= 1'b0;
        end else begin
            dl_q       <= ioctl_download;
            ioctl_wait <= (count >= WAIT_LVL);
            case (state)
                PASS: begin
                    if (ioctl_download && !dl_q) begin
                        state <= HANDOFF;
                    end
                end
                HANDOFF: begin
                    // Wait out any pending UART byte so it is never dropped.
                    if (!uart_ready) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (pop) begin
                        if (keep) begin
                            out_byte  <= kept_byte;
                            cr_follow <= (kept_byte == CH_CR);
                            state     <= PRESENT;
                        end
                    end else if (!ioctl_download) begin
                        state <= PASS;
                    end
                end
                PRESENT: begin
                    if (rx_ack) begin
                        gap_cnt <= (out_byte == CH_CR) ? CR_GAP_C : CHAR_GAP_C;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= FETCH;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

    // HANDOFF still presents the UART so a byte in flight completes normally.
    assign pass_path = (state == PASS) || (state == HANDOFF);
    assign rx_data   = pass_path ? uart_data : out_byte;
    assign rx_ready  = pass_path ? uart_ready : (state == PRESENT);
    assign uart_ack  = pass_path && rx_ack;
    assign busy      = !pass_path;

endmodule

// File: tb/tb_ascii_loader.sv
// Directed bench for ascii_loader: pass-through, filtering, pacing, backpressure, handoff and reset.
// Short gaps (CHAR_GAP=4, CR_GAP=10) keep the pacing measurements small.
module tb_ascii_loader;

    localparam int CHAR_GAP = 4;
    localparam int CR_GAP   = 10;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       ioctl_download = 1'b0;
    logic       ioctl_wr = 1'b0;
    logic [7:0] ioctl_data = 8'h00;
    logic       ioctl_wait;
    logic [7:0] uart_data = 8'h00;
    logic       uart_ready = 1'b0;
    logic       uart_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack = 1'b0;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    ascii_loader #(
        .FIFO_AW (4),
        .CHAR_GAP(CHAR_GAP),
        .CR_GAP  (CR_GAP)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_data    (ioctl_data),
        .ioctl_wait    (ioctl_wait),
        .uart_data     (uart_data),
        .uart_ready    (uart_ready),
        .uart_ack      (uart_ack),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .rx_ack        (rx_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        rx_ack         = 1'b0;
        uart_ready     = 1'b0;
        uart_data      = 8'h00;
        step();
        step();
        n_reset = 1'b1;
        step();
    endtask

    task automatic write_byte(input logic [7:0] b);
        int guard = 0;
        while (ioctl_wait === 1'b1 && guard < 500) begin
            step();
            guard++;
        end
        if (guard >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_wait_timeout: ioctl_wait stuck at %b, required 0", ioctl_wait);
        end
        ioctl_data = b;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int guard = 0;
        while (rx_ready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: rx_ready never rose (got %b, required 1)", name, rx_ready);
        end
    endtask

    // Acks the presented byte, checks rx_ready drops, and returns clocks from ack to next rx_ready.
    task automatic ack_measure(input string name, output int n);
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        n_checks++;
        if (rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drop: rx_ready after ack got %b, required 0", name, rx_ready);
        end
        n = 0;
        while (rx_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic wait_idle(input string name, output int n, output bit extra);
        n     = 0;
        extra = 1'b0;
        while (busy !== 1'b0 && n < 100) begin
            if (rx_ready === 1'b1) extra = 1'b1;
            step();
            n++;
        end
        n_checks++;
        if (busy !== 1'b0 || extra) begin
            n_fail++;
            $display("FAIL %s: busy=%b extra_byte=%b after %0d clocks, required busy 0 and no extra byte",
                     name, busy, extra, n);
        end
    endtask

    task automatic test_reset();
        n_reset    = 1'b0;
        uart_data  = 8'h41;
        uart_ready = 1'b1;
        step();
        step();
        n_reset = 1'b1;
        step();
        n_checks++;
        if (rx_data !== 8'h41) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %h, required 41", rx_data);
        end
        n_checks++;
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rx_ready: got %b, required 1", rx_ready);
        end
        n_checks++;
        if (busy !== 1'b0 || ioctl_wait !== 1'b0 || uart_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b ioctl_wait=%b uart_ack=%b, required 0 0 0", busy, ioctl_wait, uart_ack);
        end
        rx_ack = 1'b1;
        #1;
        n_checks++;
        if (uart_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ack_echo: uart_ack got %b, required 1", uart_ack);
        end
        step();
        rx_ack     = 1'b0;
        uart_ready = 1'b0;
        step();
    endtask

    task automatic test_download();
        int n;
        bit extra;
        do_reset();
        ioctl_download = 1'b1;
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(8'h0D);
        write_byte(8'h0A);
        ioctl_download = 1'b0;
        wait_ready("dl_first");
        n_checks++;
        if (rx_data !== 8'h41 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL dl_byte0: rx_data=%h busy=%b, required 41 1", rx_data, busy);
        end
        ack_measure("dl_gap_a", n);
        n_checks++;
        if (n !== CHAR_GAP + 2 || rx_data !== 8'h42) begin
            n_fail++;
            $display("FAIL dl_byte1: gap=%0d rx_data=%h, required %0d 42", n, rx_data, CHAR_GAP + 2);
        end
        ack_measure("dl_gap_b", n);
        n_checks++;
        if (n !== CHAR_GAP + 2 || rx_data !== 8'h0D) begin
            n_fail++;
            $display("FAIL dl_byte2: gap=%0d rx_data=%h, required %0d 0d", n, rx_data, CHAR_GAP + 2);
        end
        // After the CR: gap of CR_GAP+2 to the LF pop (discarded), one more clock back to PASS.
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        wait_idle("dl_return_pass", n, extra);
        n_checks++;
        if (n !== CR_GAP + 3) begin
            n_fail++;
            $display("FAIL dl_pass_latency: got %0d clocks, required %0d", n, CR_GAP + 3);
        end
    endtask

    task automatic test_filter();
        int n;
        bit extra;
        do_reset();
        ioctl_download = 1'b1;
        write_byte(8'h00);
        write_byte(8'h0A);
        write_byte(8'hC1);
        ioctl_download = 1'b0;
        wait_ready("flt_first");
        n_checks++;
        if (rx_data !== 8'h0D) begin
            n_fail++;
            $display("FAIL flt_lf_to_cr: rx_data got %h, required 0d", rx_data);
        end
        ack_measure("flt_cr_gap", n);
        n_checks++;
        if (n !== CR_GAP + 2) begin
            n_fail++;
            $display("FAIL flt_cr_gap_len: got %0d clocks, required %0d", n, CR_GAP + 2);
        end
        n_checks++;
        if (rx_data !== 8'h41) begin
            n_fail++;
            $display("FAIL flt_bit7: rx_data got %h, required 41", rx_data);
        end
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        wait_idle("flt_end", n, extra);
    endtask

    task automatic test_back_to_back();
        int writes_done = 0;
        bit stalled = 1'b0;
        int n;
        bit extra;
        do_reset();
        ioctl_download = 1'b1;
        fork
            begin : writer
                for (int i = 0; i < 20; i++) begin
                    if (ioctl_wait === 1'b1 && !stalled) begin
                        stalled = 1'b1;
                        n_checks++;
                        if (writes_done !== 16) begin
                            n_fail++;
                            $display("FAIL b2b_wait_point: ioctl_wait rose after %0d writes, required 16", writes_done);
                        end
                    end
                    write_byte(8'(8'h30 + i));
                    writes_done++;
                end
            end
            begin : reader
                int guard = 0;
                while (ioctl_wait !== 1'b1 && guard < 100) begin
                    step();
                    guard++;
                end
                n_checks++;
                if (ioctl_wait !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_wait_assert: ioctl_wait got %b, required 1", ioctl_wait);
                end
                step();
                step();
                step();
                n_checks++;
                if (ioctl_wait !== 1'b1 || rx_ready !== 1'b1 || rx_data !== 8'h30) begin
                    n_fail++;
                    $display("FAIL b2b_hold: ioctl_wait=%b rx_ready=%b rx_data=%h, required 1 1 30",
                             ioctl_wait, rx_ready, rx_data);
                end
                for (int j = 0; j < 20; j++) begin
                    wait_ready("b2b_ready");
                    n_checks++;
                    if (rx_data !== 8'(8'h30 + j)) begin
                        n_fail++;
                        $display("FAIL b2b_order: byte %0d got %h, required %h", j, rx_data, 8'(8'h30 + j));
                    end
                    rx_ack = 1'b1;
                    step();
                    rx_ack = 1'b0;
                end
            end
        join
        ioctl_download = 1'b0;
        wait_idle("b2b_end", n, extra);
        n_checks++;
        if (ioctl_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_wait_release: ioctl_wait got %b, required 0", ioctl_wait);
        end
    endtask

    task automatic test_handoff();
        int n;
        bit extra;
        do_reset();
        uart_data      = 8'h55;
        uart_ready     = 1'b1;
        ioctl_download = 1'b1;
        write_byte(8'h5A);
        step();
        step();
        n_checks++;
        if (rx_data !== 8'h55 || rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ho_uart_hold: rx_data=%h rx_ready=%b, required 55 1", rx_data, rx_ready);
        end
        rx_ack = 1'b1;
        #1;
        n_checks++;
        if (uart_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL ho_uart_ack: uart_ack got %b, required 1", uart_ack);
        end
        step();
        rx_ack     = 1'b0;
        uart_ready = 1'b0;
        uart_data  = 8'h00;
        step();
        n_checks++;
        if (busy !== 1'b1 || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ho_takeover: busy=%b rx_ready=%b, required 1 0", busy, rx_ready);
        end
        step();
        n_checks++;
        if (rx_ready !== 1'b1 || rx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL ho_first_byte: rx_ready=%b rx_data=%h, required 1 5a", rx_ready, rx_data);
        end
        rx_ack = 1'b1;
        #1;
        n_checks++;
        if (uart_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ho_ack_blocked: uart_ack got %b, required 0", uart_ack);
        end
        step();
        rx_ack         = 1'b0;
        ioctl_download = 1'b0;
        wait_idle("ho_end", n, extra);
    endtask

    task automatic test_reset_mid();
        ioctl_download = 1'b0;
        do_reset();
        ioctl_download = 1'b1;
        for (int i = 0; i < 6; i++) begin
            write_byte(8'(8'h61 + i));
        end
        wait_ready("rm_present");
        n_checks++;
        if (dut.count !== 5'd5 || rx_data !== 8'h61) begin
            n_fail++;
            $display("FAIL rm_queued: count=%0d rx_data=%h, required 5 61", dut.count, rx_data);
        end
        n_reset        = 1'b0;
        ioctl_download = 1'b0;
        step();
        n_reset = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || ioctl_wait !== 1'b0 || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_state: busy=%b ioctl_wait=%b rx_ready=%b, required 0 0 0", busy, ioctl_wait, rx_ready);
        end
        n_checks++;
        if (dut.count !== 5'd0) begin
            n_fail++;
            $display("FAIL rm_flush: count got %0d, required 0", dut.count);
        end
        for (int k = 0; k < 8; k++) step();
        n_checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_quiet: busy=%b rx_ready=%b, required 0 0", busy, rx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_download();
        test_filter();
        test_back_to_back();
        test_handoff();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
